sync_fifo: RTL and testbench

- Single-clock synchronous FIFO buffering WIDTH-bit words, DEPTH entries deep.
- Generic storage block used between producer and consumer logic in the same clock domain.
- Write/read enables with full/empty status flags.
- Registered read data: a word appears on data_out the clock edge after it is popped.

---
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo.sv | 96 +++++++++
 tb/tb_sync_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake and data bundle between a sync_fifo and its producer/consumer.
// The master side drives requests and write data; the slave side is the FIFO.
interface sync_fifo_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;

    modport master (
        output wr_en,
        output rd_en,
        output data_in,
        input  data_out,
        input  empty,
        input  full
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  data_in,
        output data_out,
        output empty,
        output full
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH words of WIDTH bits with a registered read port.
// DEPTH need not be a power of two, so the pointers wrap on an explicit compare.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic          clk,
    input  logic          n_reset,
    sync_fifo_if.slave    bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] data_out_r;

    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             wr_accept_s;
    logic             rd_accept_s;
    logic             empty_s;
    logic             full_s;

    // Flags come from the registered count only; requests are qualified against them.
    always_comb begin
        empty_s     = (count_r == {CW{1'b0}});
        full_s      = (count_r == CW'(DEPTH));
        wr_accept_s = bus.wr_en && !full_s;
        rd_accept_s = bus.rd_en && !empty_s;
    end

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_accept_s) begin
            if (wr_ptr_r == PTR_LAST) begin
                wr_ptr_nxt_s = {PW{1'b0}};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r + PW'(1);
            end
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_accept_s) begin
            if (rd_ptr_r == PTR_LAST) begin
                rd_ptr_nxt_s = {PW{1'b0}};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r + PW'(1);
            end
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, count and read-data registers; reset discards all stored words.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            if (rd_accept_s) begin
                data_out_r <= mem_r[rd_ptr_r];
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    assign bus.data_out = data_out_r;
    assign bus.empty    = empty_s;
    assign bus.full     = full_s;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue scoreboard tracks stored words and
// the expected read data, plus a table of hand-derived vectors and corner sequences.
module tb_sync_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 10;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk;
    logic n_reset;
    int   checks;
    int   errors;
    logic [7:0] mq[$];
    logic [7:0] exp_dout;
    logic [7:0] data_seq;
    vec_t vt[8];

    sync_fifo_if #(.WIDTH(WIDTH)) bus ();

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests, update the scoreboard, and compare after the edge.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] d);
        bit wr_ok;
        bit rd_ok;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = d;
        wr_ok = wr && (mq.size() < DEPTH);
        rd_ok = rd && (mq.size() != 0);
        if (rd_ok) exp_dout = mq.pop_front();
        if (wr_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        chk("data_out", 32'(bus.data_out), 32'(exp_dout));
        chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
        chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_dout = 8'h00;
        data_seq = 8'h00;

        vt[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00};
        vt[1] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00};
        vt[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h11};
        vt[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h22};
        vt[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h33};
        vt[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h33};
        vt[6] = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 8'h33};
        vt[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h44};

        // Reset held with random activity on the inputs.
        n_reset     = 1'b0;
        bus.wr_en   = 1'($urandom);
        bus.rd_en   = 1'($urandom);
        bus.data_in = 8'($urandom);
        #100;
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_full", 32'(bus.full), 32'd0);
        chk("reset_dout", 32'(bus.data_out), 32'd0);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        n_reset   = 1'b1;
        @(posedge clk);
        #1;

        // Reset pulse in the middle of traffic takes effect before any edge.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b0, 1'b1, 8'h00);
        n_reset = 1'b0;
        #2;
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_full", 32'(bus.full), 32'd0);
        chk("async_dout", 32'(bus.data_out), 32'd0);
        mq.delete();
        exp_dout = 8'h00;
        #2;
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // Table of hand-derived vectors from the empty state.
        for (int i = 0; i < 8; i++) begin
            cycle(vt[i].wr, vt[i].rd, vt[i].din);
            chk("vec_empty", 32'(bus.empty), 32'(vt[i].exp_empty));
            chk("vec_full", 32'(bus.full), 32'(vt[i].exp_full));
            chk("vec_dout", 32'(bus.data_out), 32'(vt[i].exp_dout));
        end

        // Fill: full rises exactly with the 10th write; an 11th write is dropped.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom_range(0, 169)));
            chk("fill_full", 32'(bus.full), 32'(i == DEPTH - 1));
        end
        cycle(1'b1, 1'b0, 8'hAA);
        chk("overflow_full", 32'(bus.full), 32'd1);

        // Drain: order kept, 0xAA never appears, extra read holds data_out.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk("drain_not_aa", 32'(bus.data_out == 8'hAA), 32'd0);
            chk("drain_empty", 32'(bus.empty), 32'(i == DEPTH - 1));
        end
        cycle(1'b0, 1'b1, 8'h00);
        chk("underflow_hold", 32'(bus.data_out), 32'(exp_dout));

        // Wrap-around: 25 rounds of 7 writes then 7 reads with incrementing data.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 7; i++) begin
                cycle(1'b1, 1'b0, data_seq);
                data_seq = data_seq + 8'd1;
            end
            for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00);
        end
        chk("wrap_last", 32'(bus.data_out), 32'd174);

        // Simultaneous read and write with 5 words stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 8'($urandom));
            chk("simul_flags", 32'({bus.empty, bus.full}), 32'd0);
        end

        // Both requests while full: read only, full falls.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
        chk("prefull", 32'(bus.full), 32'd1);
        cycle(1'b1, 1'b1, 8'h5A);
        chk("full_both_full", 32'(bus.full), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 8'h00);
        chk("drained", 32'(bus.empty), 32'd1);

        // Both requests while empty: write only, no read-through.
        exp_dout = bus.data_out;
        cycle(1'b1, 1'b1, 8'hC3);
        chk("empty_both_empty", 32'(bus.empty), 32'd0);
        cycle(1'b0, 1'b1, 8'h00);
        chk("empty_both_word", 32'(bus.data_out), 32'h0C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
